fifo_port_sched: RTL and testbench

//  Shares the single 8-deep x 32-bit FIFO between N write requesters and one reader.

---
 rtl/fifo_port_sched.sv | 101 ++++++++++
 tb/tb_fifo_port_sched.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_port_sched.sv
// Round-robin write arbiter and read/write serialiser in front of one FIFO.
// Reads win over writes; grants are bounded to BURST words.
module fifo_port_sched #(
  parameter int N     = 4,
  parameter int W     = 32,
  parameter int BURST = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] data,
  output logic [N-1:0]   ack,
  output logic [2:0]     grant_id,
  output logic           busy,
  input  logic           rd_req,
  output logic           rd_valid,
  input  logic           fifo_full,
  input  logic           fifo_empty,
  output logic           fifo_wr,
  output logic           fifo_rd,
  output logic           fifo_en,
  output logic [W-1:0]   fifo_din
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(BURST + 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t        state;
  logic [IW-1:0] gid;
  logic [IW-1:0] last;
  logic [IW-1:0] pick;
  logic [IW-1:0] idx;
  logic [CW-1:0] cnt;
  logic          found;
  logic          wr_ok;

  assign busy     = (state == GRANT);
  assign grant_id = 3'(gid);
  assign fifo_rd  = rd_req & ~fifo_empty;
  assign wr_ok    = busy & req[gid] & ~fifo_full & ~fifo_rd;
  assign fifo_wr  = wr_ok;
  assign fifo_en  = fifo_wr | fifo_rd;
  assign fifo_din = data[W*gid +: W];

  always_comb begin
    ack = '0;
    if (wr_ok) ack[gid] = 1'b1;
  end

  // first requester after the last holder, wrapping modulo N
  always_comb begin
    found = 1'b0;
    pick  = last;
    idx   = '0;
    for (int k = 1; k <= N; k++) begin
      idx = IW'((int'(last) + k) % N);
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      gid      <= '0;
      last     <= IW'(N - 1);
      cnt      <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= fifo_rd;
      unique case (state)
        IDLE: begin
          if (found) begin
            gid   <= pick;
            cnt   <= '0;
            state <= GRANT;
          end
        end
        GRANT: begin
          if (wr_ok) begin
            if (cnt == CW'(BURST - 1)) begin
              last  <= gid;
              state <= IDLE;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end else if (!req[gid]) begin
            last  <= gid;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_port_sched.sv
// Randomised bench for fifo_port_sched with an 8-deep FIFO environment.
// A transaction-level model predicts outputs; a monitor pops and compares.
module tb_fifo_port_sched;

  localparam int N     = 4;
  localparam int W     = 32;
  localparam int BURST = 4;
  localparam int DEPTH = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] data;
  logic [N-1:0]   ack;
  logic [2:0]     grant_id;
  logic           busy;
  logic           rd_req;
  logic           rd_valid;
  logic           fifo_full;
  logic           fifo_empty;
  logic           fifo_wr;
  logic           fifo_rd;
  logic           fifo_en;
  logic [W-1:0]   fifo_din;

  fifo_port_sched #(.N(N), .W(W), .BURST(BURST)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .data      (data),
    .ack       (ack),
    .grant_id  (grant_id),
    .busy      (busy),
    .rd_req    (rd_req),
    .rd_valid  (rd_valid),
    .fifo_full (fifo_full),
    .fifo_empty(fifo_empty),
    .fifo_wr   (fifo_wr),
    .fifo_rd   (fifo_rd),
    .fifo_en   (fifo_en),
    .fifo_din  (fifo_din)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] ack;
    logic         busy;
    logic         gchk;
    logic [2:0]   gid;
    logic         wr;
    logic         rd;
    logic         en;
    logic         rdv;
    logic [W-1:0] dout;
    logic [W-1:0] din;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // FIFO environment, driven only by the DUT's FIFO pins
  logic [W-1:0] envq[$];
  logic [W-1:0] env_dout;

  // producers
  logic         preq[N];
  logic [W-1:0] pdat[N];
  int           left[N];
  int           p_req;
  int           p_rd;

  // reference model: owner=-1 means no grant held
  int           owner;
  int           prev;
  int           taken;
  logic         m_rdv;
  logic [W-1:0] m_dout;
  logic [W-1:0] mq[$];

  function automatic void chk(input string nm, input logic [W-1:0] act,
                              input logic [W-1:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, want, $time);
    end
  endfunction

  task automatic mreset();
    owner = -1;
    prev  = N - 1;
    taken = 0;
    m_rdv = 1'b0;
    mq.delete();
  endtask

  task automatic step(input logic r);
    exp_t         e;
    logic         e_rd, e_wr;
    int           n_owner, n_prev, n_taken;
    logic [N-1:0] s_ack;
    logic         s_wr, s_rd, s_en;
    logic [W-1:0] s_din;
    @(negedge clk);
    rst = r;
    if (r) envq.delete();
    rd_req = ($urandom_range(99) < p_rd);
    for (int i = 0; i < N; i++) begin
      req[i]        = preq[i];
      data[i*W +: W] = pdat[i];
    end
    fifo_full  = (envq.size() == DEPTH);
    fifo_empty = (envq.size() == 0);
    e = '{default: '0};
    e_rd = 1'b0;
    e_wr = 1'b0;
    n_owner = owner;
    n_prev  = prev;
    n_taken = taken;
    if (r) begin
      e.gchk = 1'b1;
    end else begin
      e_rd = rd_req && !fifo_empty;
      e_wr = (owner >= 0) && preq[owner] && !fifo_full && !e_rd;
      e.rd   = e_rd;
      e.wr   = e_wr;
      e.en   = e_rd | e_wr;
      e.busy = (owner >= 0);
      e.gchk = (owner >= 0);
      if (owner >= 0) e.gid = 3'(owner);
      if (e_wr) begin
        e.ack[owner] = 1'b1;
        e.din        = pdat[owner];
      end
      e.rdv  = m_rdv;
      e.dout = m_dout;
      if (owner < 0) begin
        for (int k = 1; k <= N; k++) begin
          if (preq[(prev + k) % N]) begin
            n_owner = (prev + k) % N;
            n_taken = 0;
            break;
          end
        end
      end else if (e_wr) begin
        n_taken = taken + 1;
        if (n_taken == BURST) begin
          n_owner = -1;
          n_prev  = owner;
        end
      end else if (!preq[owner]) begin
        n_owner = -1;
        n_prev  = owner;
      end
    end
    exp_q.push_back(e);
    #1;
    s_ack = ack;
    s_wr  = fifo_wr;
    s_rd  = fifo_rd;
    s_en  = fifo_en;
    s_din = fifo_din;
    @(posedge clk);
    if (!r) begin
      if (s_en && s_rd && envq.size() > 0) env_dout = envq.pop_front();
      else if (s_en && s_wr && envq.size() < DEPTH) envq.push_back(s_din);
    end
    if (r) begin
      mreset();
    end else begin
      if (e_wr) mq.push_back(pdat[owner]);
      if (e_rd && mq.size() > 0) m_dout = mq.pop_front();
      m_rdv = e_rd;
      owner = n_owner;
      prev  = n_prev;
      taken = n_taken;
    end
    for (int i = 0; i < N; i++) begin
      if (preq[i] && s_ack[i]) begin
        left[i]--;
        preq[i] = 1'b0;
      end
      if (!preq[i] && left[i] > 0 && $urandom_range(99) < p_req) begin
        preq[i] = 1'b1;
        pdat[i] = $urandom;
      end
    end
  endtask

  task automatic quiesce();
    for (int i = 0; i < N; i++) begin
      left[i] = 0;
      preq[i] = 1'b0;
    end
    repeat (2) step(1'b1);
  endtask

  // monitor
  initial begin
    exp_t me;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        me = exp_q.pop_front();
        chk("ack", ack, me.ack);
        chk("busy", busy, me.busy);
        if (me.gchk) chk("grant_id", grant_id, me.gid);
        chk("fifo_wr", fifo_wr, me.wr);
        chk("fifo_rd", fifo_rd, me.rd);
        chk("fifo_en", fifo_en, me.en);
        chk("rd_valid", rd_valid, me.rdv);
        if (me.wr) chk("fifo_din", fifo_din, me.din);
        if (me.rdv) chk("read_word", env_dout, me.dout);
      end
    end
  end

  initial begin
    rst        = 1'b1;
    req        = '0;
    data       = '0;
    rd_req     = 1'b0;
    fifo_full  = 1'b0;
    fifo_empty = 1'b1;
    env_dout   = '0;
    mreset();
    p_req = 100;
    p_rd  = 100;
    for (int i = 0; i < N; i++) begin
      preq[i] = 1'b1;
      pdat[i] = $urandom;
      left[i] = 1000;
    end
    // reset with every port requesting and a read pending
    repeat (3) step(1'b1);
    // held requests: round robin with bubbles, reads stalling writes
    p_rd = 30;
    repeat (80) step(1'b0);

    // single port, six words, no reads
    quiesce();
    left[1] = 6;
    p_req   = 100;
    p_rd    = 0;
    repeat (20) step(1'b0);
    chk("t2_fifo_count", envq.size(), 6);
    chk("t2_words_left", left[1], 0);

    // reset in the middle of a burst from port 3
    quiesce();
    left[3] = 20;
    for (int c = 0; c < 50 && !(owner == 3 && taken == 2); c++) step(1'b0);
    repeat (2) step(1'b1);
    left[0] = 8;
    repeat (30) step(1'b0);

    // random traffic with mixed pressure and mid-stream resets
    for (int ph = 0; ph < 6; ph++) begin
      quiesce();
      for (int i = 0; i < N; i++) left[i] = 1000;
      p_req = $urandom_range(100, 30);
      p_rd  = $urandom_range(70, 5);
      repeat (300) step(1'b0);
    end

    @(negedge clk);
    #3;
    chk("exp_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
